// File: rtl/pio_sense_in_if.sv
// Avalon-MM slave register bus for the sensor input PIO.
// Zero-wait-state reads: readdata follows address combinationally.
interface pio_sense_in_if #(
    parameter int unsigned WIDTH = 8
);
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [WIDTH-1:0] writedata;
    logic [WIDTH-1:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/pio_sense_in.sv
// Sensor input PIO: synchronizes and debounces WIDTH async pins, captures selected edges
// into a write-1-clear register and raises a masked level interrupt.
module pio_sense_in #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    pio_sense_in_if.slave    bus,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);
    localparam int unsigned          CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] db_q, db_d;
    logic [WIDTH-1:0] db_prev_q;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] edge_sel_q, edge_sel_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] rise, fall, edge_hit, clr;
    logic             wr;

    assign wr = bus.chipselect & ~bus.write_n;

    // A pin change is accepted only after sync2 differs from db for DEBOUNCE_CYCLES cycles;
    // any return to db before then drops the partial count.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign rise     = db_q & ~db_prev_q;
    assign fall     = ~db_q & db_prev_q;
    assign edge_hit = (rise & ~edge_sel_q) | (fall & edge_sel_q);

    always_comb begin
        edge_sel_d = edge_sel_q;
        irq_mask_d = irq_mask_q;
        clr        = '0;
        if (wr) begin
            unique case (bus.address)
                2'd1:    edge_sel_d = bus.writedata;
                2'd2:    irq_mask_d = bus.writedata;
                2'd3:    clr        = bus.writedata;
                default: ;
            endcase
        end
        // A new edge beats a simultaneous write-1-clear of the same bit.
        cap_d = (cap_q & ~clr) | edge_hit;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            db_q       <= '0;
            db_prev_q  <= '0;
            edge_sel_q <= '0;
            irq_mask_q <= '0;
            cap_q      <= '0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= in_port;
            sync2_q    <= sync1_q;
            db_q       <= db_d;
            db_prev_q  <= db_q;
            edge_sel_q <= edge_sel_d;
            irq_mask_q <= irq_mask_d;
            cap_q      <= cap_d;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        bus.readdata = '0;
        unique case (bus.address)
            2'd0: bus.readdata = db_q;
            2'd1: bus.readdata = edge_sel_q;
            2'd2: bus.readdata = irq_mask_q;
            2'd3: bus.readdata = cap_q;
            default: ;
        endcase
    end

    assign irq = |(cap_q & irq_mask_q);
endmodule

// File: tb/tb_pio_sense_in.sv
// Scoreboard bench for pio_sense_in: stimulus queues expected register/irq values per read,
// a monitor pops and compares them when the read strobe fires.
module tb_pio_sense_in;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned DB    = 16;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [WIDTH-1:0] in_port = '0;
    logic             irq;
    logic             rd_strobe = 1'b0;

    pio_sense_in_if #(.WIDTH(WIDTH)) bus ();

    pio_sense_in #(
        .WIDTH          (WIDTH),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus),
        .in_port(in_port),
        .irq    (irq)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [1:0]       addr;
        logic [WIDTH-1:0] data;
        logic             irq;
        string            name;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge rd_strobe) begin
        exp_t e;
        #1;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_read: no expected entry queued");
        end else begin
            e = exp_q.pop_front();
            if (bus.readdata !== e.data || irq !== e.irq) begin
                n_bad++;
                $display("FAIL %s: addr %0d got data 0x%02h irq %b, want data 0x%02h irq %b",
                         e.name, e.addr, bus.readdata, irq, e.data, e.irq);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input logic [1:0] a, input logic [WIDTH-1:0] d, input logic i,
                         input string nm);
        exp_t e;
        bus.address = a;
        e.addr = a;
        e.data = d;
        e.irq  = i;
        e.name = nm;
        exp_q.push_back(e);
        rd_strobe = 1'b1;
        #2;
        rd_strobe = 1'b0;
        #1;
    endtask

    task automatic write(input logic [1:0] a, input logic [WIDTH-1:0] d, input logic cs);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = cs;
        bus.write_n    = 1'b0;
        @(posedge clk);
        #1;
        bus.write_n    = 1'b1;
        bus.chipselect = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;

        #3;
        check(2'd0, 8'h00, 1'b0, "reset_data");
        check(2'd1, 8'h00, 1'b0, "reset_edge_sel");
        check(2'd2, 8'h00, 1'b0, "reset_irq_mask");
        check(2'd3, 8'h00, 1'b0, "reset_cap");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick(2);

        // Register access
        write(2'd2, 8'h04, 1'b1);
        check(2'd2, 8'h04, 1'b0, "irq_mask_rw");
        write(2'd2, 8'hFF, 1'b0);
        check(2'd2, 8'h04, 1'b0, "cs_gates_write");
        write(2'd0, 8'hFF, 1'b1);
        check(2'd0, 8'h00, 1'b0, "data_read_only");
        write(2'd1, 8'hA5, 1'b1);
        check(2'd1, 8'hA5, 1'b0, "edge_sel_rw");
        check(2'd3, 8'h00, 1'b0, "edge_sel_no_cap");
        write(2'd1, 8'h00, 1'b1);

        // Glitch of 10 cycles is rejected
        in_port = 8'h01;
        tick(10);
        in_port = 8'h00;
        tick(25);
        check(2'd0, 8'h00, 1'b0, "glitch_data");
        check(2'd3, 8'h00, 1'b0, "glitch_cap");

        // Accepted change: DATA at E1+17, capture and irq at E1+18
        in_port = 8'h05;
        tick(17);
        check(2'd0, 8'h00, 1'b0, "db_before_accept");
        tick(1);
        check(2'd0, 8'h05, 1'b0, "db_after_accept");
        check(2'd3, 8'h00, 1'b0, "cap_before_edge");
        tick(1);
        check(2'd3, 8'h05, 1'b1, "cap_and_irq");
        write(2'd3, 8'h04, 1'b1);
        check(2'd3, 8'h01, 1'b0, "w1c_drops_irq");

        // Falling-edge select
        write(2'd1, 8'h01, 1'b1);
        check(2'd3, 8'h01, 1'b0, "sel_keeps_cap");
        write(2'd3, 8'hFF, 1'b1);
        check(2'd3, 8'h00, 1'b0, "cap_clear_all");
        in_port = 8'h04;
        tick(20);
        check(2'd0, 8'h04, 1'b0, "fall_data");
        check(2'd3, 8'h01, 1'b0, "fall_captured");
        write(2'd3, 8'h01, 1'b1);
        in_port = 8'h05;
        tick(20);
        check(2'd0, 8'h05, 1'b0, "rise_data");
        check(2'd3, 8'h00, 1'b0, "rise_ignored");

        // Clear and capture of bit 3 on the same edge
        in_port = 8'h0D;
        tick(18);
        write(2'd3, 8'h08, 1'b1);
        check(2'd3, 8'h08, 1'b0, "collision_set_wins");
        tick(1);
        check(2'd3, 8'h08, 1'b0, "collision_hold");
        write(2'd3, 8'h08, 1'b1);
        check(2'd3, 8'h00, 1'b0, "w1c_after_collision");

        // Reset at debounce count 8
        write(2'd2, 8'hFF, 1'b1);
        in_port = 8'h8D;
        tick(10);
        reset_n = 1'b0;
        #1;
        check(2'd0, 8'h00, 1'b0, "midreset_data");
        check(2'd1, 8'h00, 1'b0, "midreset_edge_sel");
        check(2'd2, 8'h00, 1'b0, "midreset_irq_mask");
        check(2'd3, 8'h00, 1'b0, "midreset_cap");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick(17);
        check(2'd0, 8'h00, 1'b0, "post_reset_before");
        tick(1);
        check(2'd0, 8'h8D, 1'b0, "post_reset_accept");
        tick(1);
        check(2'd3, 8'h8D, 1'b0, "post_reset_cap");

        for (int k = 0; k < 50 && exp_q.size() != 0; k++) begin
            tick(1);
        end
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pio_sense_in.md
# pio_sense_in

Avalon-MM slave input port for the core board's digital sensors (ball infrared detectors, limit switches, and similar). It is the read-side counterpart of the single-bit output PIO that the CPU drives: it samples WIDTH asynchronous pins, synchronizes and debounces them, latches selected edges, and raises an interrupt to the Nios CPU. Register reads are zero-wait-state. The block sits on the same Avalon-MM system interconnect as the other PIO slaves.

## Interface
- WIDTH, 8: number of input pins and register data width (1..32).
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required before a pin change is accepted (>= 1).
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
- writedata  in  WIDTH  write data.
- readdata  out  WIDTH  read data, combinational from address; Avalon read latency 0.
- in_port  in  WIDTH  asynchronous sensor pins.
- irq  out  1  level interrupt to the CPU.

## Operation
- Register map:
  - 0 DATA: debounced pin state, read-only. Writes are ignored.
  - 1 EDGE_SEL: read/write. Per bit, 0 captures rising edges and 1 captures falling edges.
  - 2 IRQ_MASK: read/write.
  - 3 EDGECAPTURE: read; a write of 1 clears the bit, a write of 0 leaves it unchanged.
- readdata equals the selected register whenever address is valid. It does not depend on chipselect.
- Synchronizer: two flops per bit, sync1 feeding sync2.
- Debounce: one counter per bit, width clog2(DEBOUNCE_CYCLES+1).
  - If sync2 equals db, the counter is 0.
  - Otherwise the counter increments.
  - When sync2≠db and the counter equals DEBOUNCE_CYCLES-1, db takes sync2 and the counter goes to 0.
  - Any return of sync2 to db before that point resets the counter to 0. Partial counts never carry over.
- Edge detect: db_d is a one-cycle-delayed copy of db.
  - A rise is db=1 with db_d=0; a fall is db=0 with db_d=1.
  - A detected edge of the type selected in EDGE_SEL sets the EDGECAPTURE bit on the next clock.
- Clear/set collision: if an edge set and a write-1-clear hit the same bit in the same cycle, the set wins and the bit ends at 1.
- irq = OR over bits of (EDGECAPTURE & IRQ_MASK). It is combinational from registers and has no extra latency.
- Changing EDGE_SEL does not modify EDGECAPTURE.
- Reset values (all outputs and state 0): sync1, sync2, db, db_d, counters, EDGE_SEL, IRQ_MASK, EDGECAPTURE. So readdata=0 at address 0 and irq=0.
  - A pin held high through reset is accepted after debounce and produces a rising edge, captured if EDGE_SEL bit is 0. Software clears it after init.
- Reset mid-debounce: the counter and all state return to 0 immediately, asynchronously.

## Timing
- Pin to sync2: in_port, meeting setup before edge E1, appears in sync2 after edge E2.
- sync2 to db: db updates at edge E2+DEBOUNCE_CYCLES, if the pin stays stable throughout.
- db to EDGECAPTURE: the bit sets at edge E2+DEBOUNCE_CYCLES+1; irq asserts in the same cycle as the capture if the bit is masked on.
- Total pin-to-irq latency: DEBOUNCE_CYCLES+3 clock edges, counting E1.
- Register write: the value is visible on readdata in the cycle after the write edge.
- Glitch rejection: a pulse with sync2 stable for fewer than DEBOUNCE_CYCLES cycles never reaches db.

## Test plan
- Glitch rejection (WIDTH=8, DEBOUNCE_CYCLES=16): in_port[0] high for 10 cycles, then low -> DATA stays 0x00, EDGECAPTURE stays 0x00, irq stays 0.
- Accepted change: in_port=0x05 held from edge E1 -> DATA reads 0x00 up to edge E1+16 and 0x05 from edge E1+17. EDGECAPTURE reads 0x05 from E1+18.
- Interrupt path: IRQ_MASK=0x04, rising on bit 2 -> irq=1 from the capture edge. Write EDGECAPTURE=0x04 -> irq=0 next cycle. Bit 0 stays captured and irq stays 0 because bit 0 is masked.
- Falling select: EDGE_SEL=0x01, bit 0 goes 1->0 -> EDGECAPTURE[0]=1. A subsequent 0->1 on bit 0 does not set it.
- Collision: a write-1-clear of EDGECAPTURE[3] in the same cycle as a new bit-3 capture -> EDGECAPTURE[3]=1 afterward.
- Reset mid-debounce: pin changed, reset_n pulsed low at count 8 -> all registers read 0 and irq=0. After release, the still-high pin is accepted 2+16 cycles later.
